// File: rtl/branch_ctrl.sv
// branch_ctrl: ID-stage branch sequencer. Holds IF/ID while branch operands are in flight,
// puts the comparator in compare-with-zero mode for single-operand branches, and on the
// resolve cycle redirects the PC and flushes IF/ID if the branch is taken.
// Optional feature macro: BRANCH_PERF_EN adds saturating taken/not-taken/wait counters.
module branch_ctrl
`ifdef BRANCH_PERF_EN
#(
  parameter int unsigned CNT_W = 16
)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
`ifdef BRANCH_PERF_EN
  input  logic             perf_clr,
  output logic [CNT_W-1:0] perf_taken,
  output logic [CNT_W-1:0] perf_not_taken,
  output logic [CNT_W-1:0] perf_wait,
`endif
  input  logic             br_valid,
  input  logic [2:0]       br_type,
  input  logic [31:0]      br_target,
  input  logic             rs_busy,
  input  logic             rt_busy,
  input  logic             ext_flush,
  input  logic [1:0]       cmp_result,
  output logic             cmp_zero,
  output logic             stall,
  output logic             pc_sel,
  output logic [31:0]      pc_target,
  output logic             flush
);

  // Branch type encodings
  localparam logic [2:0] BrBeq  = 3'b000;
  localparam logic [2:0] BrBne  = 3'b001;
  localparam logic [2:0] BrBltz = 3'b010;
  localparam logic [2:0] BrBgtz = 3'b011;
  localparam logic [2:0] BrBlez = 3'b100;
  localparam logic [2:0] BrBgez = 3'b101;

  // Comparator result encodings
  localparam logic [1:0] CmpEqual = 2'b00;
  localparam logic [1:0] CmpLt    = 2'b01;
  localparam logic [1:0] CmpGt    = 2'b10;

  typedef enum logic [1:0] {StIdle, StWait, StResolve} state_e;

  state_e      state_q, state_d;
  logic [2:0]  type_q, type_d;
  logic [31:0] target_q, target_d;

  logic accept;
  logic need_new;
  logic need_held;
  logic taken;

  // Only the two-register compares consume rt.
  function automatic logic rt_needed(input logic [2:0] t);
    return (t == BrBeq) || (t == BrBne);
  endfunction

  function automatic logic uses_cmp0(input logic [2:0] t);
    return (t == BrBltz) || (t == BrBgtz) || (t == BrBlez) || (t == BrBgez);
  endfunction

  // Illegal types and the DEFAULT compare result fall through to not-taken.
  function automatic logic br_taken(input logic [2:0] t, input logic [1:0] c);
    logic eq, lt, gt;
    eq = (c == CmpEqual);
    lt = (c == CmpLt);
    gt = (c == CmpGt);
    case (t)
      BrBeq:   return eq;
      BrBne:   return lt | gt;
      BrBltz:  return lt;
      BrBgtz:  return gt;
      BrBlez:  return lt | eq;
      BrBgez:  return gt | eq;
      default: return 1'b0;
    endcase
  endfunction

  assign accept    = (state_q == StIdle) && br_valid && !ext_flush;
  assign need_new  = rs_busy | (rt_needed(br_type) & rt_busy);
  assign need_held = rs_busy | (rt_needed(type_q) & rt_busy);
  assign taken     = br_taken(type_q, cmp_result);
  assign pc_target = target_q;

  // State and captured-branch registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      type_q   <= 3'b000;
      target_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      target_q <= target_d;
    end
  end

  // Next-state logic; ext_flush overrides every transition
  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    target_d = target_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          type_d   = br_type;
          target_d = br_target;
          state_d  = need_new ? StWait : StResolve;
        end
      end
      StWait: begin
        if (!need_held) state_d = StResolve;
      end
      StResolve: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if (ext_flush) state_d = StIdle;
  end

  // Output decode
  always_comb begin
    stall    = 1'b0;
    pc_sel   = 1'b0;
    flush    = 1'b0;
    cmp_zero = 1'b0;
    unique case (state_q)
      StIdle: begin
        stall    = accept;
        cmp_zero = accept & uses_cmp0(br_type);
      end
      StWait: begin
        stall    = !ext_flush;
        cmp_zero = uses_cmp0(type_q);
      end
      StResolve: begin
        pc_sel   = taken & !ext_flush;
        flush    = taken & !ext_flush;
        cmp_zero = uses_cmp0(type_q);
      end
      default: ;
    endcase
  end

`ifdef BRANCH_PERF_EN
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] perf_taken_q, perf_taken_d;
  logic [CNT_W-1:0] perf_not_taken_q, perf_not_taken_d;
  logic [CNT_W-1:0] perf_wait_q, perf_wait_d;

  // Saturating counters; clear beats increment
  always_comb begin
    perf_taken_d     = perf_taken_q;
    perf_not_taken_d = perf_not_taken_q;
    perf_wait_d      = perf_wait_q;
    if (perf_clr) begin
      perf_taken_d     = '0;
      perf_not_taken_d = '0;
      perf_wait_d      = '0;
    end else begin
      if ((state_q == StResolve) && !ext_flush) begin
        if (taken) begin
          if (perf_taken_q != CntMax) perf_taken_d = perf_taken_q + CNT_W'(1);
        end else begin
          if (perf_not_taken_q != CntMax) perf_not_taken_d = perf_not_taken_q + CNT_W'(1);
        end
      end
      if ((state_q == StWait) && (perf_wait_q != CntMax)) begin
        perf_wait_d = perf_wait_q + CNT_W'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_taken_q     <= '0;
      perf_not_taken_q <= '0;
      perf_wait_q      <= '0;
    end else begin
      perf_taken_q     <= perf_taken_d;
      perf_not_taken_q <= perf_not_taken_d;
      perf_wait_q      <= perf_wait_d;
    end
  end

  assign perf_taken     = perf_taken_q;
  assign perf_not_taken = perf_not_taken_q;
  assign perf_wait      = perf_wait_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed stimulus for branch_ctrl with a per-cycle reference model.
// Define BRANCH_PERF_EN to also exercise the perf counters (built with CNT_W = 4).
module tb_branch_ctrl;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BGTZ = 3'b011;
  localparam logic [1:0] EQ   = 2'b00;
  localparam logic [1:0] GT   = 2'b10;

  // Row = branch type, bit = compare result (0 EQ, 1 LT, 2 GT, 3 DEFAULT)
  localparam logic [3:0] TakenTbl [8] = '{4'b0001, 4'b0110, 4'b0010, 4'b0100,
                                         4'b0011, 4'b0101, 4'b0000, 4'b0000};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_valid = 1'b0;
  logic [2:0]  br_type = 3'b000;
  logic [31:0] br_target = 32'h0;
  logic        rs_busy = 1'b0;
  logic        rt_busy = 1'b0;
  logic        ext_flush = 1'b0;
  logic [1:0]  cmp_result = 2'b11;
  logic        cmp_zero, stall, pc_sel, flush;
  logic [31:0] pc_target;

  int n_pass = 0;
  int n_total = 0;

`ifdef BRANCH_PERF_EN
  localparam int PerfW = 4;
  localparam int PerfMax = (1 << PerfW) - 1;
  logic             perf_clr = 1'b0;
  logic [PerfW-1:0] perf_taken, perf_not_taken, perf_wait;

  branch_ctrl #(.CNT_W(PerfW)) dut (
    .clk(clk), .rst_n(rst_n), .perf_clr(perf_clr), .perf_taken(perf_taken),
    .perf_not_taken(perf_not_taken), .perf_wait(perf_wait),
    .br_valid(br_valid), .br_type(br_type), .br_target(br_target), .rs_busy(rs_busy),
    .rt_busy(rt_busy), .ext_flush(ext_flush), .cmp_result(cmp_result),
    .cmp_zero(cmp_zero), .stall(stall), .pc_sel(pc_sel), .pc_target(pc_target),
    .flush(flush));
`else
  branch_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .br_valid(br_valid), .br_type(br_type), .br_target(br_target), .rs_busy(rs_busy),
    .rt_busy(rt_busy), .ext_flush(ext_flush), .cmp_result(cmp_result),
    .cmp_zero(cmp_zero), .stall(stall), .pc_sel(pc_sel), .pc_target(pc_target),
    .flush(flush));
`endif

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // held: a branch occupies ID; ready: its operands are available so it resolves now.
  bit          m_held, m_ready, n_held, n_ready;
  logic [2:0]  m_type, n_type;
  logic [31:0] m_target, n_target;
  logic        e_stall, e_psel, e_cz;
  logic [3:0]  row;
  int          m_pt, m_pn, m_pw, n_pt, n_pn, n_pw;

  function automatic bit need_f(input logic [2:0] t, input logic rs, input logic rt);
    return rs || ((t < 3'd2) && rt);
  endfunction

  function automatic bit cz_f(input logic [2:0] t);
    return (t >= 3'd2) && (t <= 3'd5);
  endfunction

  initial begin
    n_held = 0; n_ready = 0; n_type = 0; n_target = 0; n_pt = 0; n_pn = 0; n_pw = 0;
  end

  // Compute expected outputs for this cycle, compare, and prepare the model's next state
  always @(negedge clk) begin
    e_stall = 1'b0; e_psel = 1'b0; e_cz = 1'b0; row = 4'b0;
    n_held = m_held; n_ready = m_ready; n_type = m_type; n_target = m_target;
    n_pt = m_pt; n_pn = m_pn; n_pw = m_pw;
    if (!m_held) begin
      if (br_valid && !ext_flush) begin
        e_stall = 1'b1;
        e_cz = cz_f(br_type);
        n_held = 1; n_type = br_type; n_target = br_target;
        n_ready = !need_f(br_type, rs_busy, rt_busy);
      end
    end else if (!m_ready) begin
      e_stall = !ext_flush;
      e_cz = cz_f(m_type);
      if (ext_flush) n_held = 0;
      else n_ready = !need_f(m_type, rs_busy, rt_busy);
      n_pw = m_pw + 1;
    end else begin
      row = TakenTbl[m_type];
      e_psel = row[cmp_result] && !ext_flush;
      e_cz = cz_f(m_type);
      n_held = 0;
      if (!ext_flush) begin
        if (row[cmp_result]) n_pt = m_pt + 1;
        else n_pn = m_pn + 1;
      end
    end
`ifdef BRANCH_PERF_EN
    if (n_pt > PerfMax) n_pt = PerfMax;
    if (n_pn > PerfMax) n_pn = PerfMax;
    if (n_pw > PerfMax) n_pw = PerfMax;
    if (perf_clr) begin n_pt = 0; n_pn = 0; n_pw = 0; end
`endif
    if (rst_n) begin
      chk1("model_stall", stall, e_stall);
      chk1("model_pc_sel", pc_sel, e_psel);
      chk1("model_flush", flush, e_psel);
      chk1("model_cmp_zero", cmp_zero, e_cz);
      if (e_psel) chk32("model_pc_target", pc_target, m_target);
`ifdef BRANCH_PERF_EN
      chk32("model_perf_taken", 32'(perf_taken), m_pt);
      chk32("model_perf_not_taken", 32'(perf_not_taken), m_pn);
      chk32("model_perf_wait", 32'(perf_wait), m_pw);
`endif
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_held <= 0; m_ready <= 0; m_type <= 0; m_target <= 0;
      m_pt <= 0; m_pn <= 0; m_pw <= 0;
    end else begin
      m_held <= n_held; m_ready <= n_ready; m_type <= n_type; m_target <= n_target;
      m_pt <= n_pt; m_pn <= n_pn; m_pw <= n_pw;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [2:0] t, input logic [31:0] tg,
                       input logic rs, input logic rt, input logic ef, input logic [1:0] c);
    br_valid = v; br_type = t; br_target = tg;
    rs_busy = rs; rt_busy = rt; ext_flush = ef; cmp_result = c;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    chk1("reset_stall", stall, 1'b0);
    chk1("reset_pc_sel", pc_sel, 1'b0);
    chk1("reset_flush", flush, 1'b0);
    chk1("reset_cmp_zero", cmp_zero, 1'b0);
    chk32("reset_pc_target", pc_target, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // BEQ, operands ready, EQUAL: stall at T, redirect at T+1
    drive(1, BEQ, 32'h0040_0020, 0, 0, 0, EQ);
    settle();
    chk1("t1_accept_stall", stall, 1'b1);
    chk1("t1_accept_pc_sel", pc_sel, 1'b0);
    next_cyc();
    settle();
    chk1("t1_resolve_stall", stall, 1'b0);
    chk1("t1_resolve_pc_sel", pc_sel, 1'b1);
    chk1("t1_resolve_flush", flush, 1'b1);
    chk32("t1_pc_target", pc_target, 32'h0040_0020);
    next_cyc();
    drive(0, BEQ, 32'h0, 0, 0, 0, EQ);
    next_cyc();

    // BNE with rt busy 3 cycles: 4 stall cycles then a not-taken resolve
    drive(1, BNE, 32'h0000_1000, 0, 1, 0, EQ);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) rt_busy = 1'b0;
      settle();
      chk1("t2_wait_stall", stall, 1'b1);
      next_cyc();
    end
    settle();
    chk1("t2_resolve_stall", stall, 1'b0);
    chk1("t2_resolve_pc_sel", pc_sel, 1'b0);
    chk1("t2_resolve_flush", flush, 1'b0);
    next_cyc();
    drive(0, BEQ, 32'h0, 0, 0, 0, EQ);
    next_cyc();

    // Zero-compare branches, back to back; rt_busy must not cause a wait
    for (int t = 2; t <= 5; t++) begin
      for (int c = 0; c < 4; c++) begin
        drive(1, 3'(t), 32'h2000 + 32'(t * 16 + c * 4), 0, 1, 0, 2'(c));
        settle();
        chk1("t3_accept_cmp_zero", cmp_zero, 1'b1);
        chk1("t3_accept_stall", stall, 1'b1);
        next_cyc();
        settle();
        chk1("t3_resolve_stall", stall, 1'b0);
        chk1("t3_resolve_cmp_zero", cmp_zero, 1'b1);
        next_cyc();
      end
    end
    drive(0, BEQ, 32'h0, 0, 0, 0, EQ);
    next_cyc();
    // Hand-derived: BLEZ on LT is taken, BGTZ on EQ is not
    drive(1, 3'b100, 32'h0000_7000, 0, 0, 0, 2'b01);
    next_cyc();
    settle();
    chk1("t3_blez_lt_taken", pc_sel, 1'b1);
    next_cyc();
    drive(1, BGTZ, 32'h0000_7004, 0, 0, 0, EQ);
    next_cyc();
    settle();
    chk1("t3_bgtz_eq_not_taken", pc_sel, 1'b0);
    next_cyc();
    drive(0, BEQ, 32'h0, 0, 0, 0, EQ);
    next_cyc();

    // ext_flush in WAIT, in RESOLVE, and in IDLE
    drive(1, BEQ, 32'h0000_3000, 1, 0, 0, EQ);
    settle();
    chk1("t4_accept_stall", stall, 1'b1);
    next_cyc();
    ext_flush = 1'b1;
    settle();
    chk1("t4_wait_flush_stall", stall, 1'b0);
    next_cyc();
    drive(0, BEQ, 32'h0, 0, 0, 0, EQ);
    settle();
    chk1("t4_after_flush_stall", stall, 1'b0);
    next_cyc();
    drive(1, BEQ, 32'h0000_3004, 0, 0, 0, EQ);
    next_cyc();
    ext_flush = 1'b1;
    settle();
    chk1("t4_resolve_flush_pc_sel", pc_sel, 1'b0);
    chk1("t4_resolve_flush_flush", flush, 1'b0);
    chk1("t4_resolve_flush_stall", stall, 1'b0);
    next_cyc();
    drive(1, BEQ, 32'h0000_3008, 0, 0, 1, EQ);
    settle();
    chk1("t4_idle_flush_blocks", stall, 1'b0);
    next_cyc();
    drive(0, BEQ, 32'h0, 0, 0, 0, EQ);
    next_cyc();

    // Async reset pulse mid-WAIT, then an illegal type
    drive(1, BEQ, 32'h0000_4000, 1, 0, 0, EQ);
    next_cyc();
    br_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk1("t5_reset_stall", stall, 1'b0);
    chk1("t5_reset_pc_sel", pc_sel, 1'b0);
    chk1("t5_reset_flush", flush, 1'b0);
    chk32("t5_reset_pc_target", pc_target, 32'h0);
    #1 rst_n = 1'b1;
    settle();
    chk1("t5_after_reset_stall", stall, 1'b0);
    next_cyc();
    drive(1, 3'b110, 32'h0000_5000, 0, 0, 0, EQ);
    settle();
    chk1("t5_illegal_stall", stall, 1'b1);
    chk1("t5_illegal_cmp_zero", cmp_zero, 1'b0);
    next_cyc();
    settle();
    chk1("t5_illegal_stall_done", stall, 1'b0);
    chk1("t5_illegal_not_taken", pc_sel, 1'b0);
    next_cyc();
    drive(0, BEQ, 32'h0, 0, 0, 0, EQ);
    next_cyc();

    // 20 back-to-back taken branches
    drive(1, BGTZ, 32'h0000_6000, 0, 0, 0, GT);
    repeat (40) next_cyc();
    drive(0, BEQ, 32'h0, 0, 0, 0, EQ);
    settle();
`ifdef BRANCH_PERF_EN
    chk32("t6_perf_taken_sat", 32'(perf_taken), 32'd15);
    chk32("t6_perf_not_taken", 32'(perf_not_taken), 32'd1);
    chk32("t6_perf_wait", 32'(perf_wait), 32'd0);
    next_cyc();
    perf_clr = 1'b1;
    next_cyc();
    perf_clr = 1'b0;
    settle();
    chk32("t6_perf_clr_taken", 32'(perf_taken), 32'd0);
    chk32("t6_perf_clr_not_taken", 32'(perf_not_taken), 32'd0);
`else
    chk1("t6_idle_stall", stall, 1'b0);
`endif
    next_cyc();
    next_cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
